// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI frame definitions: FSM states, frame geometry and the frame builder
// used by the SPI initiator.
package spi_master_ctrl_pkg;

    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_ADDR_BITS  = 7;
    localparam int SPI_DATA_BITS  = 8;

    localparam logic SPI_RW_READ  = 1'b1;
    localparam logic SPI_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    // Read frames clock out zeros in the data phase while the memory answers on miso.
    function automatic logic [SPI_FRAME_BITS-1:0] build_frame(
        input logic [SPI_ADDR_BITS-1:0] addr,
        input logic                     rw,
        input logic [SPI_DATA_BITS-1:0] wdata
    );
        return {addr, rw, (rw == SPI_RW_WRITE) ? wdata : {SPI_DATA_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SPI clock generator: counts CLK_DIV system clocks per half-period and toggles
// sclk on each half-period boundary when toggling is allowed.
module spi_master_ctrl_sclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle_en,
    output logic half_tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    // Disabled means held in reset so every frame starts from a clean half-period.
    always_comb begin
        half_tick = en && (cnt_q == CNT_LAST);
        rise_tick = half_tick && toggle_en && !sclk_q;
        fall_tick = half_tick && toggle_en && sclk_q;

        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else begin
            cnt_d = half_tick ? '0 : cnt_q + 1'b1;
            if (rise_tick) begin
                sclk_d = 1'b1;
            end else if (fall_tick) begin
                sclk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator (CPOL=0, CPHA=0): one 16-bit frame {addr, rw, data} per host
// request, capturing the returned byte on reads.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     rw,
    input  logic [SPI_ADDR_BITS-1:0] addr,
    input  logic [SPI_DATA_BITS-1:0] wdata,
    output logic [SPI_DATA_BITS-1:0] rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     sclk,
    output logic                     cs_n,
    output logic                     mosi,
    input  logic                     miso
);

    localparam int HP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int HPW    = $clog2(HP_MAX) + 1;
    localparam int BW     = $clog2(SPI_FRAME_BITS);

    localparam logic [HPW-1:0] SETUP_LAST = HPW'(CS_SETUP - 1);
    localparam logic [HPW-1:0] HOLD_LAST  = HPW'(CS_HOLD - 1);
    localparam logic [BW-1:0]  LAST_BIT   = BW'(SPI_FRAME_BITS - 1);

    spi_state_e                state_q, state_d;
    logic [HPW-1:0]            hp_q, hp_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [SPI_FRAME_BITS-1:0] tx_q, tx_d;
    logic [SPI_DATA_BITS-1:0]  sr_q, sr_d;
    logic [SPI_DATA_BITS-1:0]  rdata_q, rdata_d;
    logic                      rw_q, rw_d;
    logic                      cs_n_q, cs_n_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic gen_en, toggle_en;
    logic half_tick, rise_tick, fall_tick;

    assign gen_en    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign toggle_en = (state_q == SHIFT);

    spi_master_ctrl_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (gen_en),
        .toggle_en (toggle_en),
        .half_tick (half_tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sclk      (sclk)
    );

    // The shift register only keeps the last data-phase bits, which are all rdata needs.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        sr_d    = sr_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    tx_d    = build_frame(addr, rw, wdata);
                    rw_d    = rw;
                    hp_d    = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    if (hp_q == SETUP_LAST) begin
                        state_d = SHIFT;
                        hp_d    = '0;
                    end else begin
                        hp_d = hp_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (rise_tick) begin
                    sr_d = {sr_q[SPI_DATA_BITS-2:0], miso};
                end
                if (fall_tick) begin
                    tx_d = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
                    if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    if (hp_q == HOLD_LAST) begin
                        state_d = DONE;
                        hp_d    = '0;
                        if (rw_q == SPI_RW_READ) begin
                            rdata_d = sr_q;
                        end
                    end else begin
                        hp_d = hp_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hp_q    <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            sr_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            sr_q    <= sr_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The frame MSB is mosi; shifting on each sclk fall keeps it stable while sclk is high.
    assign mosi  = tx_q[SPI_FRAME_BITS-1];
    assign cs_n  = cs_n_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule
